inst_queue: RTL and testbench

Decoupling FIFO between the second fetch stage and instruction decode. It captures each fetched instruction word, its PC and its fetch-exception code, and presents them in order to decode through a valid/ready handshake. It absorbs decode back-pressure without stalling instruction memory, and discards all buffered entries on a branch redirect or exception flush.

---
 rtl/inst_queue_pkg.sv | 22 ++
 rtl/inst_queue_mem.sv | 29 ++
 rtl/inst_queue.sv | 107 ++++++++++
 tb/tb_inst_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the instruction queue between fetch and decode.
// Optional feature macro used by inst_queue: INST_QUEUE_BYPASS_EN.
package inst_queue_pkg;

    // Default number of queue entries (power of two, at least 2).
    localparam int DEFAULT_DEPTH = 4;

    // Fetch exception codes, {address-error, fetch-fault}.
    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_FAULT = 2'b01;
    localparam logic [1:0] EXC_ADDR  = 2'b10;

    // One queued fetch result.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  exc;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/inst_queue_mem.sv
// Entry storage for inst_queue: DEPTH x entry_t register array,
// one synchronous write port, one asynchronous read port.
module inst_queue_mem
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    // Write port: capture the pushed entry at the clock edge.
    // NOTE: storage has no reset; validity is tracked by the pointers, so its contents never matter while empty.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Decoupling FIFO between fetch stage 2 and decode. Holds {inst, pc, exc}
// and hands them to decode in order over valid/ready; flush drops everything.
// Optional feature macro: INST_QUEUE_BYPASS_EN (empty-queue combinational bypass).
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic [1:0]       in_exc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_inst,
    output logic [31:0]      out_pc,
    output logic [1:0]       out_exc,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam int AW = CNT_W - 1;

    logic [CNT_W-1:0] wr_ptr;
    logic [CNT_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             bypass;
    logic             push;
    logic             pop;
    entry_t           in_entry;
    entry_t           head;
    entry_t           out_entry;

    // Low bits equal: same slot. MSB tells whether the writer has lapped the reader.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]);

`ifdef INST_QUEUE_BYPASS_EN
    // An empty queue forwards the incoming entry straight to decode when it can take it.
    assign bypass = empty && in_valid && out_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    // A full queue refuses the push even if decode pops in the same cycle,
    // which keeps in_ready free of any path from out_ready.
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush && !bypass;
    assign pop      = !empty && out_ready && !flush;
    assign count    = wr_ptr - rd_ptr;

    assign in_entry = '{inst: in_inst, pc: in_pc, exc: in_exc};

    inst_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    // Pointer update: flush wins over push and pop.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Output selection: head entry, bypassed input, or zeros when nothing is valid.
    // NOTE: out_entry gets a default first so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        out_entry = '0;
        if (!empty) begin
            out_entry = head;
        end else if (bypass) begin
            out_entry = in_entry;
        end
    end

    assign out_valid = !empty || bypass;
    assign out_inst  = out_entry.inst;
    assign out_pc    = out_entry.pc;
    assign out_exc   = out_entry.exc;

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (DEPTH = 4).
// Exercises reset, latency, full refusal, simultaneous push/pop, pointer wrap,
// flush priority, asynchronous reset and (when INST_QUEUE_BYPASS_EN is defined) bypass.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic [1:0]       in_exc;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_inst;
    logic [31:0]      out_pc;
    logic [1:0]       out_exc;
    logic             out_ready;
    logic [CNT_W-1:0] count;

    int n_checks = 0;
    int n_errors = 0;

    inst_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .out_exc   (out_exc),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_exc    = EXC_NONE;
        out_ready = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic [1:0] exc, input logic rdy);
        in_valid  = v;
        in_inst   = inst;
        in_pc     = pc;
        in_exc    = exc;
        out_ready = rdy;
    endtask

    // One clock edge, then return inputs to idle and let outputs settle.
    task automatic cycle();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    logic [31:0] t_inst [4];
    logic [31:0] t_pc   [4];
    logic [1:0]  t_exc  [4];

    initial begin
        t_inst = '{32'ha000_0001, 32'h0000_0000, 32'ha000_0003, 32'ha000_0004};
        t_pc   = '{32'hbfc0_0100, 32'hbfc0_0104, 32'hbfc0_0108, 32'hbfc0_010c};
        t_exc  = '{EXC_NONE, EXC_FAULT, EXC_ADDR, EXC_NONE};

        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     64'(count),     64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_inst",  64'(out_inst),  64'd0);
        check("rst_out_pc",    64'(out_pc),    64'd0);
        check("rst_out_exc",   64'(out_exc),   64'd0);
        reset = 1'b0;
        #1;

        // Single push, visible after one edge.
        drive(1'b1, 32'h2408_0001, 32'hbfc0_0000, EXC_NONE, 1'b0);
        cycle();
        check("t1_out_valid", 64'(out_valid), 64'd1);
        check("t1_out_inst",  64'(out_inst),  64'h2408_0001);
        check("t1_out_pc",    64'(out_pc),    64'hbfc0_0000);
        check("t1_count",     64'(count),     64'd1);
        drive(1'b0, '0, '0, EXC_NONE, 1'b1);
        cycle();
        check("t1_drained_count", 64'(count),     64'd0);
        check("t1_drained_valid", 64'(out_valid), 64'd0);

        // Fill to DEPTH; a bubble (inst 0) and nonzero exc codes are stored as-is.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t_inst[i], t_pc[i], t_exc[i], 1'b0);
            cycle();
        end
        check("t2_full_count",    64'(count),    64'd4);
        check("t2_full_in_ready", 64'(in_ready), 64'd0);
        check("t2_head0_inst",    64'(out_inst), 64'(t_inst[0]));
        // Push into full queue while popping: push refused, pop happens.
        drive(1'b1, 32'h1111_1111, 32'hbfc0_0110, EXC_NONE, 1'b1);
        cycle();
        check("t2_refused_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t2_pop%0d_inst", i), 64'(out_inst), 64'(t_inst[i]));
            check($sformatf("t2_pop%0d_pc", i),   64'(out_pc),   64'(t_pc[i]));
            check($sformatf("t2_pop%0d_exc", i),  64'(out_exc),  64'(t_exc[i]));
            drive(1'b0, '0, '0, EXC_NONE, 1'b1);
            cycle();
        end
        check("t2_empty_valid", 64'(out_valid), 64'd0);
        check("t2_empty_inst",  64'(out_inst),  64'd0);

        // Simultaneous push and pop at count = 2.
        drive(1'b1, 32'hc000_0001, 32'hbfc0_0200, EXC_NONE, 1'b0);
        cycle();
        drive(1'b1, 32'hc000_0002, 32'hbfc0_0204, EXC_NONE, 1'b0);
        cycle();
        check("t3_count_before", 64'(count), 64'd2);
        drive(1'b1, 32'hc000_0003, 32'hbfc0_0208, EXC_NONE, 1'b1);
        cycle();
        check("t3_count_after", 64'(count),    64'd2);
        check("t3_head",        64'(out_inst), 64'hc000_0002);
        drive(1'b0, '0, '0, EXC_NONE, 1'b1);
        cycle();
        check("t3_head2", 64'(out_inst), 64'hc000_0003);
        drive(1'b0, '0, '0, EXC_NONE, 1'b1);
        cycle();
        check("t3_drained", 64'(count), 64'd0);

        // Ten push/pop pairs: pointers wrap twice, order preserved.
        drive(1'b1, 32'h2000_0000, 32'hbfc0_0000, EXC_NONE, 1'b0);
        cycle();
        for (int k = 1; k < 10; k++) begin
            check($sformatf("t4_pc%0d", k - 1), 64'(out_pc), 64'(32'hbfc0_0000 + 32'(4 * (k - 1))));
            drive(1'b1, 32'h2000_0000 + 32'(k), 32'hbfc0_0000 + 32'(4 * k), EXC_NONE, 1'b1);
            cycle();
        end
        check("t4_pc9", 64'(out_pc), 64'hbfc0_0024);
        drive(1'b0, '0, '0, EXC_NONE, 1'b1);
        cycle();
        check("t4_drained", 64'(count), 64'd0);

        // Flush at count = 3 drops the queue and the same-cycle input.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'he000_0000 + 32'(i), 32'hbfc0_0300 + 32'(4 * i), EXC_NONE, 1'b0);
            cycle();
        end
        check("t5_count_before", 64'(count), 64'd3);
        drive(1'b1, 32'hdead_beef, 32'hbfc0_0400, EXC_ADDR, 1'b1);
        flush = 1'b1;
        cycle();
        check("t5_count",     64'(count),     64'd0);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        check("t5_out_inst",  64'(out_inst),  64'd0);
        drive(1'b1, 32'h1234_5678, 32'hbfc0_0500, EXC_NONE, 1'b0);
        cycle();
        check("t5_after_count", 64'(count),    64'd1);
        check("t5_after_head",  64'(out_inst), 64'h1234_5678);

        // Asynchronous reset mid-cycle clears state without a clock edge.
        drive(1'b1, 32'h5555_0000, 32'hbfc0_0504, EXC_NONE, 1'b0);
        cycle();
        check("t6_count_before", 64'(count), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_count", 64'(count),     64'd0);
        check("t6_async_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Empty queue with in_valid and out_ready together.
        drive(1'b1, 32'h7777_0001, 32'hbfc0_0600, EXC_ADDR, 1'b1);
        #1;
`ifdef INST_QUEUE_BYPASS_EN
        check("t7_byp_valid", 64'(out_valid), 64'd1);
        check("t7_byp_exc",   64'(out_exc),   64'(EXC_ADDR));
        check("t7_byp_inst",  64'(out_inst),  64'h7777_0001);
        cycle();
        check("t7_byp_count", 64'(count),     64'd0);
        check("t7_byp_after", 64'(out_valid), 64'd0);
`else
        check("t7_nobyp_valid", 64'(out_valid), 64'd0);
        check("t7_nobyp_exc",   64'(out_exc),   64'd0);
        cycle();
        check("t7_nobyp_count", 64'(count),   64'd1);
        check("t7_nobyp_exc2",  64'(out_exc), 64'(EXC_ADDR));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
